// File: rtl/softex_pkg.sv
// Shared types and default widths for the SoftEx input cast sequencer.
package softex_pkg;

  localparam int unsigned LEN_W      = 16;
  localparam int unsigned INT_BITS_W = 8;
  localparam int unsigned PERF_W     = 32;

  typedef struct packed {
    logic                  enable;
    logic                  is_signed;
    logic [INT_BITS_W-1:0] int_bits;
  } cast_ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cast_state_e;

endpackage

// File: rtl/softex_cast_ctrl_if.sv
// Gated beat stream between the streamer source and the cast stage.
// Handshake: a beat transfers in a cycle where valid and ready are both high;
// valid must not wait on ready, and ready may depend combinationally on the far side.
interface softex_cast_ctrl_if;
  logic src_valid;
  logic src_ready;
  logic cast_valid;
  logic cast_ready;
  logic last;

  // master: the gating controller
  modport master (
    input  src_valid, cast_ready,
    output src_ready, cast_valid, last
  );

  // slave: source/cast-stage environment around the controller
  modport slave (
    output src_valid, cast_ready,
    input  src_ready, cast_valid, last
  );
endinterface

// File: rtl/softex_cast_ctrl.sv
// Job sequencer for the SoftEx input cast stage: latches cfg/len on start,
// passes exactly len beats, pulses done. Optional perf counters: SOFTEX_CAST_PERF_EN.
module softex_cast_ctrl
  import softex_pkg::*;
#(
  parameter int unsigned LEN_W  = softex_pkg::LEN_W,
  parameter int unsigned PERF_W = softex_pkg::PERF_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  cast_ctrl_t          cfg_i,
  input  logic [LEN_W-1:0]    len_i,
  output cast_ctrl_t          ctrl_o,
  softex_cast_ctrl_if.master  stream,
  output logic                busy_o,
  output logic                done_o,
  output logic [PERF_W-1:0]   stall_cnt_o,
  output logic [PERF_W-1:0]   starve_cnt_o,
  output cast_state_e         state_o
);

  cast_state_e      state_q, state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  cast_ctrl_t       ctrl_q;

  logic run;
  logic hs;
  logic last;
  logic start_acc;

  assign run       = (state_q == RUN);
  assign hs        = run & stream.src_valid & stream.cast_ready;
  assign last      = run & (cnt_q == (len_q - LEN_W'(1)));
  assign start_acc = (state_q == IDLE) & start_i & ~clear_i;

  assign stream.cast_valid = run & stream.src_valid;
  assign stream.src_ready  = run & stream.cast_ready;
  assign stream.last       = last;

  assign ctrl_o  = ctrl_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
        RUN:     if (hs && last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (start_acc) begin
        cnt_q  <= '0;
        len_q  <= len_i;
        ctrl_q <= cfg_i;
      end else if (hs) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

`ifdef SOFTEX_CAST_PERF_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] starve_q;

  // Both counters saturate rather than wrap so long jobs never read as short ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else if (clear_i || start_acc) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (run && stream.cast_valid && !stream.cast_ready && (stall_q != '1))
        stall_q <= stall_q + PERF_W'(1);
      if (run && !stream.src_valid && (starve_q != '1))
        starve_q <= starve_q + PERF_W'(1);
    end
  end

  assign stall_cnt_o  = stall_q;
  assign starve_cnt_o = starve_q;
`else
  assign stall_cnt_o  = '0;
  assign starve_cnt_o = '0;
`endif

endmodule

// File: tb/tb_softex_cast_ctrl.sv
// Directed bench for softex_cast_ctrl: beat scoreboard on the last flag plus per-cycle checks.
module tb_softex_cast_ctrl;
  import softex_pkg::*;

  localparam int unsigned LW = 16;
  localparam int unsigned PW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  cast_ctrl_t       cfg = '0;
  logic [LW-1:0]    len = '0;
  cast_ctrl_t       ctrl;
  logic             busy, done;
  logic [PW-1:0]    stall_cnt, starve_cnt;
  cast_state_e      state;

  softex_cast_ctrl_if sif ();

  softex_cast_ctrl #(.LEN_W(LW), .PERF_W(PW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .start_i      (start),
    .cfg_i        (cfg),
    .len_i        (len),
    .ctrl_o       (ctrl),
    .stream       (sif),
    .busy_o       (busy),
    .done_o       (done),
    .stall_cnt_o  (stall_cnt),
    .starve_cnt_o (starve_cnt),
    .state_o      (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back((i == n - 1) ? 1'b1 : 1'b0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      step();
      @(negedge clk);
      k++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  // scoreboard: every observed handshake pops one expected last flag
  always @(negedge clk) begin
    if (!rst && sif.cast_valid && sif.cast_ready) begin
      if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
      else check("beat_last", 64'(sif.last), 64'(exp_q.pop_front()));
    end
  end

  cast_ctrl_t cfg_a, cfg_b;
  logic [0:0] exp_last;
  logic [PW-1:0] exp_stall;

  initial begin
    cfg_a = '{enable: 1'b1, is_signed: 1'b1, int_bits: 8'd3};
    cfg_b = '{enable: 1'b0, is_signed: 1'b1, int_bits: 8'hA5};
    sif.src_valid = 1'b0;
    sif.cast_ready = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ctrl", 64'(ctrl), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    step();
    rst = 1'b0;

    // 1: len 4, full throughput
    start = 1'b1; cfg = cfg_a; len = 16'd4;
    sif.src_valid = 1'b1; sif.cast_ready = 1'b1;
    push_job(4);
    @(negedge clk);
    check("t1_idle_valid", 64'(sif.cast_valid), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);
    step();
    start = 1'b0; cfg = '0; len = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_last = (i == 3) ? 1'b1 : 1'b0;
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_valid", 64'(sif.cast_valid), 64'd1);
      check("t1_last", 64'(sif.last), 64'(exp_last));
      check("t1_ctrl", 64'(ctrl), 64'(cfg_a));
      check("t1_done_early", 64'(done), 64'd0);
      step();
    end
    @(negedge clk);
    check("t1_done", 64'(done), 64'd1);
    check("t1_done_busy", 64'(busy), 64'd1);
    check("t1_done_valid", 64'(sif.cast_valid), 64'd0);
    check("t1_done_ready", 64'(sif.src_ready), 64'd0);
    step();
    @(negedge clk);
    check("t1_idle_after", 64'(busy), 64'd0);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // 2: zero-length job
    start = 1'b1; cfg = cfg_b; len = 16'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    check("t2_done", 64'(done), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_valid", 64'(sif.cast_valid), 64'd0);
    check("t2_ctrl", 64'(ctrl), 64'(cfg_b));
    step();
    @(negedge clk);
    check("t2_idle", 64'(state), 64'(IDLE));
    check("t2_done_gone", 64'(done), 64'd0);

    // 3: len 3, cast_ready pattern 1,0,0,1,1
    start = 1'b1; cfg = cfg_a; len = 16'd3;
    push_job(3);
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sif.cast_ready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp_last = (i == 4) ? 1'b1 : 1'b0;
      check("t3_last", 64'(sif.last), 64'(exp_last));
      check("t3_ready_pass", 64'(sif.src_ready), 64'(sif.cast_ready));
      step();
    end
    sif.cast_ready = 1'b1;
    @(negedge clk);
    check("t3_done", 64'(done), 64'd1);
`ifdef SOFTEX_CAST_PERF_EN
    exp_stall = 32'd2;
`else
    exp_stall = 32'd0;
`endif
    check("t3_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    check("t3_starve_cnt", 64'(starve_cnt), 64'd0);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);
    step();

    // 4: start during RUN is ignored
    start = 1'b1; cfg = cfg_a; len = 16'd4;
    push_job(4);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin start = 1'b1; cfg = cfg_b; len = 16'd2; end
      else begin start = 1'b0; cfg = '0; len = '0; end
      @(negedge clk);
      exp_last = (i == 3) ? 1'b1 : 1'b0;
      check("t4_ctrl", 64'(ctrl), 64'(cfg_a));
      check("t4_last", 64'(sif.last), 64'(exp_last));
      step();
    end
    start = 1'b0;
    @(negedge clk);
    check("t4_done", 64'(done), 64'd1);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);
    step();

    // 5: clear after beat 2 of len 5, then a full job
    start = 1'b1; cfg = cfg_b; len = 16'd5;
    push_job(5);
    step();
    start = 1'b0;
    step();
    step();
    sif.src_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    check("t5_no_hs_on_clear", 64'(sif.cast_valid), 64'd0);
    step();
    clear = 1'b0;
    sif.src_valid = 1'b1;
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_no_done", 64'(done), 64'd0);
    check("t5_src_ready", 64'(sif.src_ready), 64'd0);
    check("t5_ctrl_kept", 64'(ctrl), 64'(cfg_b));
    step();
    start = 1'b1; cfg = cfg_a; len = 16'd5;
    push_job(5);
    step();
    start = 1'b0;
    @(negedge clk);
    wait_done("t5_rerun_done", 20);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);
    step();

    // 6: asynchronous reset mid-job
    start = 1'b1; cfg = cfg_a; len = 16'd4;
    step();
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_valid", 64'(sif.cast_valid), 64'd0);
    check("t6_ready", 64'(sif.src_ready), 64'd0);
    check("t6_last", 64'(sif.last), 64'd0);
    check("t6_ctrl", 64'(ctrl), 64'd0);
    step();
    rst = 1'b0;

    // start and clear together in IDLE
    start = 1'b1; clear = 1'b1; cfg = cfg_b; len = 16'd3;
    step();
    start = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("t6_sc_idle", 64'(state), 64'(IDLE));
    check("t6_sc_ctrl", 64'(ctrl), 64'd0);
    check("t6_sc_valid", 64'(sif.cast_valid), 64'd0);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no_finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
